// File: rtl/oagu_depth_conv_writer.sv
// Output address generator / write serializer for depthwise conv: one PE group in,
// one pixel per cycle out to the IO buffer. Optional macro OAGU_RELU_EN clamps negative pixels to 0.
module oagu_depth_conv_writer #(
    parameter int PE_COL_NUM = 8,
    parameter int DATA_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_store,
    input  logic [12:0]                  addr_start_o,
    input  logic [7:0]                   out_x_length,
    input  logic [7:0]                   out_y_length,
    input  logic [7:0]                   out_piece,
    input  logic [4:0]                   part_num,
    input  logic [3:0]                   last_part,
    input  logic                         i_group_valid,
    input  logic [PE_COL_NUM*DATA_W-1:0] i_group_data,
    output logic                         o_group_ready,
    output logic                         o_wr_en,
    output logic [12:0]                  o_wr_addr,
    output logic [DATA_W-1:0]            o_wr_data,
    output logic                         o_store_end
);
    localparam int CNT_W = $clog2(PE_COL_NUM + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_CALC1, S_CALC2, S_WRITE, S_DONE
    } state_t;

    function automatic logic [DATA_W-1:0] relu_pixel(input logic signed [DATA_W-1:0] p);
`ifdef OAGU_RELU_EN
        return (p < 0) ? '0 : p;
`else
        return p;
`endif
    endfunction

    state_t                    r_state, w_next;
    logic [12:0]               r_line_size;
    logic [4:0]                r_part;
    logic [7:0]                r_piece;
    logic [7:0]                r_row;
    logic [CNT_W-1:0]          r_k;
    logic [PE_COL_NUM*DATA_W-1:0] r_data;
    logic [12:0]               r_row_base;
    logic [12:0]               r_base;

    logic                      w_part_end, w_piece_end, w_row_end, w_last_write;
    logic [CNT_W-1:0]          w_group_num;
    logic [12:0]               w_line_size, w_row_base, w_base;
    logic [DATA_W-1:0]         w_pixel;

    assign w_part_end   = (r_part  == part_num - 5'd1);
    assign w_piece_end  = (r_piece == out_piece - 8'd1);
    assign w_row_end    = (r_row   == out_y_length - 8'd1);
    // last_part==0 encodes a full final part
    assign w_group_num  = !w_part_end ? CNT_W'(PE_COL_NUM) :
                          (last_part == 4'd0) ? CNT_W'(PE_COL_NUM) : CNT_W'(last_part);
    assign w_last_write = (r_k == w_group_num - CNT_W'(1));

    assign w_line_size = {5'd0, out_x_length} * {5'd0, out_piece};
    assign w_row_base  = {5'd0, r_row} * r_line_size;
    assign w_base      = addr_start_o + r_row_base + {5'd0, r_piece} * {5'd0, out_x_length}
                         + {8'd0, r_part} * 13'(PE_COL_NUM);
    assign w_pixel     = r_data[32'(r_k)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_store) w_next = S_WAIT;
            S_WAIT:  if (i_group_valid) w_next = S_CALC1;
            S_CALC1: w_next = S_CALC2;
            S_CALC2: w_next = S_WRITE;
            S_WRITE: if (w_last_write)
                         w_next = (w_part_end && w_piece_end && w_row_end) ? S_DONE : S_WAIT;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Loop counters advance on the last write of a group, part innermost
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_size <= '0;
            r_part      <= '0;
            r_piece     <= '0;
            r_row       <= '0;
            r_k         <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start_store) begin
                    r_line_size <= w_line_size;
                    r_part      <= '0;
                    r_piece     <= '0;
                    r_row       <= '0;
                    r_k         <= '0;
                end
                S_WAIT: r_k <= '0;
                S_WRITE: begin
                    if (w_last_write) begin
                        r_k <= '0;
                        if (!w_part_end) begin
                            r_part <= r_part + 5'd1;
                        end else begin
                            r_part <= '0;
                            if (!w_piece_end) begin
                                r_piece <= r_piece + 8'd1;
                            end else begin
                                r_piece <= '0;
                                r_row   <= r_row + 8'd1;
                            end
                        end
                    end else begin
                        r_k <= r_k + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers: always rewritten before use, so no reset
    always_ff @(posedge clk) begin
        if (r_state == S_WAIT && i_group_valid) r_data <= i_group_data;
        if (r_state == S_CALC1) r_row_base <= w_row_base;
        if (r_state == S_CALC2) r_base <= w_base;
    end

    always_comb begin
        o_group_ready = (r_state == S_WAIT);
        o_wr_en       = (r_state == S_WRITE);
        o_store_end   = (r_state == S_DONE);
        o_wr_addr     = '0;
        o_wr_data     = '0;
        if (o_wr_en) begin
            o_wr_addr = r_base + {{(13-CNT_W){1'b0}}, r_k};
            o_wr_data = relu_pixel(w_pixel);
        end
    end
endmodule

// File: tb/tb_oagu_depth_conv_writer.sv
// Directed self-checking bench for oagu_depth_conv_writer (honours OAGU_RELU_EN when defined).
module tb_oagu_depth_conv_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_store;
    logic [12:0] addr_start_o;
    logic [7:0]  out_x_length, out_y_length, out_piece;
    logic [4:0]  part_num;
    logic [3:0]  last_part;
    logic        i_group_valid;
    logic [63:0] i_group_data;
    logic        o_group_ready, o_wr_en, o_store_end;
    logic [12:0] o_wr_addr;
    logic [7:0]  o_wr_data;

    int n_checks = 0;
    int n_errors = 0;

    oagu_depth_conv_writer #(.PE_COL_NUM(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start_store(start_store), .addr_start_o(addr_start_o),
        .out_x_length(out_x_length), .out_y_length(out_y_length), .out_piece(out_piece),
        .part_num(part_num), .last_part(last_part), .i_group_valid(i_group_valid),
        .i_group_data(i_group_data), .o_group_ready(o_group_ready), .o_wr_en(o_wr_en),
        .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_store_end(o_store_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input logic [7:0] p);
`ifdef OAGU_RELU_EN
        return p[7] ? 8'h00 : p;
`else
        return p;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [12:0] a, input logic [7:0] x, input logic [7:0] pc,
                             input logic [7:0] y, input logic [4:0] pn, input logic [3:0] lp);
        addr_start_o = a; out_x_length = x; out_piece = pc;
        out_y_length = y; part_num = pn; last_part = lp;
    endtask

    task automatic do_start();
        start_store = 1'b1;
        tick();
        start_store = 1'b0;
        check("ready_after_start", 32'(o_group_ready), 1);
    endtask

    task automatic run_group(input logic [63:0] data, input logic [12:0] base, input int n,
                             input bit last, input bit hold, input logic [63:0] nxt);
        for (int i = 0; i < 20 && !o_group_ready; i++) tick();
        check("ready_wait", 32'(o_group_ready), 1);
        i_group_valid = 1'b1;
        i_group_data  = data;
        tick();
        if (hold) i_group_data = nxt;
        else      i_group_valid = 1'b0;
        check("calc1_ready", 32'(o_group_ready), 0);
        check("calc1_wr_en", 32'(o_wr_en), 0);
        tick();
        check("calc2_wr_en", 32'(o_wr_en), 0);
        for (int k = 0; k < n; k++) begin
            tick();
            check("wr_en", 32'(o_wr_en), 1);
            check("wr_addr", 32'(o_wr_addr), 32'(base + 13'(k)));
            check("wr_data", 32'(o_wr_data), 32'(exp_pix(data[k*8 +: 8])));
            check("ready_in_write", 32'(o_group_ready), 0);
        end
        tick();
        check("post_wr_en", 32'(o_wr_en), 0);
        check("post_wr_addr", 32'(o_wr_addr), 0);
        if (last) begin
            check("store_end", 32'(o_store_end), 1);
            check("done_ready", 32'(o_group_ready), 0);
            tick();
            check("idle_store_end", 32'(o_store_end), 0);
            check("idle_ready", 32'(o_group_ready), 0);
        end else begin
            check("ready_again", 32'(o_group_ready), 1);
            check("no_store_end", 32'(o_store_end), 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_store = 1'b0; i_group_valid = 1'b0; i_group_data = '0;
        configure(13'd0, 8'd8, 8'd1, 8'd1, 5'd1, 4'd8);
        tick(); tick();
        check("rst_ready", 32'(o_group_ready), 0);
        check("rst_wr_en", 32'(o_wr_en), 0);
        check("rst_addr", 32'(o_wr_addr), 0);
        check("rst_data", 32'(o_wr_data), 0);
        check("rst_store_end", 32'(o_store_end), 0);
        rst = 1'b0;
        tick();
        check("idle_no_ready", 32'(o_group_ready), 0);

        // single full group
        configure(13'd100, 8'd8, 8'd1, 8'd1, 5'd1, 4'd8);
        do_start();
        run_group(64'h0807060504030201, 13'd100, 8, 1'b1, 1'b0, '0);

        // partial last part
        configure(13'd200, 8'd11, 8'd1, 8'd1, 5'd2, 4'd3);
        do_start();
        run_group(64'h1817161514131211, 13'd200, 8, 1'b0, 1'b0, '0);
        run_group(64'h0000000000333231, 13'd208, 3, 1'b1, 1'b0, '0);

        // tiling order with backpressure and valid held through a write burst
        configure(13'd0, 8'd8, 8'd2, 8'd2, 5'd1, 4'd0);
        do_start();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_wr_en", 32'(o_wr_en), 0);
            check("bp_ready", 32'(o_group_ready), 1);
        end
        run_group(64'h4746454443424140, 13'd0, 8, 1'b0, 1'b1, 64'h5756555453525150);
        run_group(64'h5756555453525150, 13'd8, 8, 1'b0, 1'b0, '0);
        run_group(64'h6766656463626160, 13'd16, 8, 1'b0, 1'b0, '0);
        run_group(64'h7776757473727170, 13'd24, 8, 1'b1, 1'b0, '0);

        // reset during the 4th write of the third group
        configure(13'd40, 8'd8, 8'd2, 8'd2, 5'd1, 4'd0);
        do_start();
        run_group(64'h0F0E0D0C0B0A0908, 13'd40, 8, 1'b0, 1'b0, '0);
        run_group(64'h1F1E1D1C1B1A1918, 13'd48, 8, 1'b0, 1'b0, '0);
        i_group_valid = 1'b1;
        i_group_data  = 64'h2F2E2D2C2B2A2928;
        tick();
        i_group_valid = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) tick();
        check("pre_rst_addr", 32'(o_wr_addr), 32'(13'd59));
        rst = 1'b1;
        tick();
        check("rst_mid_wr_en", 32'(o_wr_en), 0);
        check("rst_mid_addr", 32'(o_wr_addr), 0);
        check("rst_mid_ready", 32'(o_group_ready), 0);
        rst = 1'b0;
        tick();
        check("rst_mid_idle", 32'(o_group_ready), 0);
        do_start();
        run_group(64'h3F3E3D3C3B3A3938, 13'd40, 8, 1'b0, 1'b0, '0);
        run_group(64'h4F4E4D4C4B4A4948, 13'd48, 8, 1'b0, 1'b0, '0);
        run_group(64'h5F5E5D5C5B5A5958, 13'd56, 8, 1'b0, 1'b0, '0);
        run_group(64'h6F6E6D6C6B6A6968, 13'd64, 8, 1'b1, 1'b0, '0);

        // negative pixels (0xF0, 0xFF, 0x80) against ReLU option
        configure(13'd8000, 8'd8, 8'd1, 8'd1, 5'd1, 4'd8);
        do_start();
        run_group(64'h7F0180FF001000F0, 13'd8000, 8, 1'b1, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
